cache_block_transfer_buffer: RTL and testbench
==============================================

Name: cache_block_transfer_buffer

Overview:
- Sits directly downstream of the set-associative cache controllers, between a cache's internal-memory-controller port and the external word-wide memory interface.
- Accepts block fill and block writeback commands (and single-word commands), buffers writeback data in a write FIFO and fill data in a read FIFO.
- Sequences the individual word transfers to external memory in strict command order.

Parameters:
- CMD_DEPTH, 2, command queue entries; must be a power of two, minimum 2.
- BLOCK_WORDS, 16, words per block; must equal 2^`BW_BLOCK.
- FIFO_DEPTH, 16, words in each data FIFO; must be at least BLOCK_WORDS.

Ports:
- clock_i  in  1  single clock; all state updates on its rising edge.
- reset_i  in  1  synchronous, active-low reset.
- req_i  in  1  command strobe from cache.
- req_block_i  in  1  1 = block command (BLOCK_WORDS words), 0 = single word.
- rw_i  in  1  0 = fill (read external memory), 1 = writeback (write external memory).
- add_i  in  `BW_WORD_ADDR  start word address; low `BW_BLOCK bits are ignored for block commands.
- write_i  in  1  push data_i into the write FIFO.
- data_i  in  32  writeback data word.
- read_i  in  1  pop the read FIFO head.
- ready_req_o  out  1  command queue not full.
- ready_write_o  out  1  write FIFO not full.
- ready_read_o  out  1  read FIFO not empty.
- data_o  out  32  read FIFO head (show-ahead).
- mem_req_o  out  1  external word request.
- mem_rw_o  out  1  0 = read, 1 = write.
- mem_add_o  out  `BW_WORD_ADDR  external word address.
- mem_data_o  out  32  external write data.
- mem_done_i  in  1  one-cycle completion pulse from external memory.
- mem_data_i  in  32  external read data; valid when mem_done_i is high.
- err_o  out  1  sticky protocol-error flag.

Behaviour:
- Reset (reset_i == 0 at a clock edge):
  - Empties all FIFOs and the queue; FSM goes to ST_IDLE.
  - Registered outputs: mem_req_o=0, mem_rw_o=0, mem_add_o=0, mem_data_o=0, err_o=0.
  - Derived outputs after reset: ready_req_o=1, ready_write_o=1, ready_read_o=0, data_o=0.
  - Reset mid-transfer abandons the transfer immediately; a mem_done_i arriving later is ignored.
- ready_* outputs are combinational from registered occupancy counts only; there is no input-to-output combinational path.
- Command queue:
  - On req_i with ready_req_o=1, {rw_i, req_block_i, add_i} is enqueued. For block commands the address is stored with the low `BW_BLOCK bits cleared.
  - req_i while full: command dropped, err_o set.
  - Push and pop in the same cycle are both honoured, and the count is unchanged.
- Write FIFO:
  - write_i while full: word dropped, err_o set.
  - Writeback data may arrive before or after its command is queued.
- Read FIFO:
  - Show-ahead; data_o is the head word, valid whenever ready_read_o=1.
  - read_i while empty: ignored, err_o set.
  - Simultaneous push (from external memory) and pop (from cache) are both honoured.
- FSM states: ST_IDLE, ST_FILL, ST_WRITEBACK.
  - ST_IDLE, head command is a fill: wait for read FIFO count <= FIFO_DEPTH - n (n = BLOCK_WORDS or 1), then pop the command, set word counter to 0, go to ST_FILL.
  - ST_IDLE, head command is a writeback: wait for write FIFO count >= n, then pop the command, set word counter to 0, go to ST_WRITEBACK.
  - ST_FILL: drive mem_req_o=1, mem_rw_o=0, mem_add_o = base + counter, and hold them until mem_done_i. On mem_done_i, push mem_data_i into the read FIFO. On the last word, return to ST_IDLE; otherwise increment the counter, with mem_req_o kept asserted.
  - ST_WRITEBACK: same sequencing with mem_rw_o=1 and mem_data_o = write FIFO head. Pop the write FIFO on mem_done_i.
  - The first mem_req_o is asserted the cycle after the command pops.
  - mem_done_i while mem_req_o=0: ignored, err_o set.
- Address arithmetic: base + counter, counter is `BW_BLOCK bits wide. Addresses never carry into the tag/group bits; wrap within the block.
- Commands complete strictly in enqueue order. A fill queued behind a writeback waits for that writeback to finish.
- Throughput bound: one word per mem_done_i cycle. With mem_done_i tied high, a block completes in BLOCK_WORDS+1 cycles from the command pop.

Decomposition:
- Shared header (cache.h):
  - `BW_WORD_ADDR and `BW_BLOCK.
  - New command-field offsets: CMD_RW, CMD_BLOCK, CMD_ADDR.
  - New state encodings: ST_IDLE, ST_FILL, ST_WRITEBACK.
- Sub-module fifo_sync_showahead (WIDTH, DEPTH): provides count, full, empty, and simultaneous push/pop. It is instantiated three times: write FIFO, read FIFO, and command queue (width `BW_WORD_ADDR+2).

Test Plan:
- Block fill: req_i, rw_i=0, block=1, add_i=0x0043 with mem_done_i tied high and mem_data_i=addr^0xA5A50000 -> mem_add_o sequence 0x0040..0x004F; ready_read_o rises; 16 read_i pops return 0xA5A50040..0xA5A5004F in order.
- Writeback data-first: push words 0..15 via write_i, then req_i rw=1 block=1 add 0x0120 -> mem_req_o rises the cycle after the pop; writes to 0x0120..0x012F with mem_data_o = 0..15; ready_write_o=1 at end.
- Writeback command-first: queue writeback at 0x0200, delay data 5 cycles -> no mem_req_o until the 16th word has been written; then normal sequence.
- Ordering/backpressure: queue fill A then writeback B, with mem_done_i every 3rd cycle -> all A reads complete before the first B write; a third req_i while ready_req_o=0 sets err_o and is not executed.
- Single word: rw=0 block=0 add 0x0007 -> exactly one mem_req_o at 0x0007; read FIFO count 1.
- Reset mid-fill: reset_i=0 after 5 words -> next cycle mem_req_o=0, ready_read_o=0, ready_req_o=1; a stale mem_done_i afterwards pushes nothing.

Source files
------------

// File: rtl/cache_block_transfer_buffer_pkg.sv
// Shared definitions for the cache block transfer buffer: address widths,
// command-word field offsets, sequencer states and small helpers.
package cache_block_transfer_buffer_pkg;

    // Word-address width and log2(words per block).
    localparam int unsigned BW_WORD_ADDR = 16;
    localparam int unsigned BW_BLOCK     = 4;

    // Command word layout: {rw, block, addr}.
    localparam int unsigned CMD_ADDR  = 0;
    localparam int unsigned CMD_BLOCK = BW_WORD_ADDR;
    localparam int unsigned CMD_RW    = BW_WORD_ADDR + 1;
    localparam int unsigned CMD_W     = BW_WORD_ADDR + 2;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_FILL      = 2'd1,
        ST_WRITEBACK = 2'd2
    } state_e;

    typedef struct packed {
        logic                    rw;
        logic                    blk;
        logic [BW_WORD_ADDR-1:0] addr;
    } cmd_t;

    // Block-aligned base address: low BW_BLOCK bits cleared.
    function automatic logic [BW_WORD_ADDR-1:0] block_base(input logic [BW_WORD_ADDR-1:0] a);
        return {a[BW_WORD_ADDR-1:BW_BLOCK], {BW_BLOCK{1'b0}}};
    endfunction

endpackage

// File: rtl/cache_block_transfer_buffer_fifo_sync_showahead.sv
// Synchronous show-ahead FIFO with occupancy count. Push while full and pop
// while empty are ignored; simultaneous push and pop are both honoured.
// DEPTH must be a power of two so the pointers wrap naturally.
module fifo_sync_showahead #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic                         clock_i,
    input  logic                         reset_i,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             data_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    // Head word is zero while empty so stale storage never leaks out.
    assign data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // Next pointer and occupancy values.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents need no reset because the count gates the head.
    always_ff @(posedge clock_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/cache_block_transfer_buffer.sv
// Cache block transfer buffer: queues fill/writeback commands from a cache
// controller, buffers writeback and fill data, and sequences word transfers
// to external memory strictly in command order.
module cache_block_transfer_buffer
    import cache_block_transfer_buffer_pkg::*;
#(
    parameter int unsigned CMD_DEPTH   = 2,
    parameter int unsigned BLOCK_WORDS = 16,
    parameter int unsigned FIFO_DEPTH  = 16
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic                    req_i,
    input  logic                    req_block_i,
    input  logic                    rw_i,
    input  logic [BW_WORD_ADDR-1:0] add_i,
    input  logic                    write_i,
    input  logic [31:0]             data_i,
    input  logic                    read_i,
    output logic                    ready_req_o,
    output logic                    ready_write_o,
    output logic                    ready_read_o,
    output logic [31:0]             data_o,
    output logic                    mem_req_o,
    output logic                    mem_rw_o,
    output logic [BW_WORD_ADDR-1:0] mem_add_o,
    output logic [31:0]             mem_data_o,
    input  logic                    mem_done_i,
    input  logic [31:0]             mem_data_i,
    output logic                    err_o
);

    localparam int unsigned CCW = $clog2(CMD_DEPTH + 1);
    localparam int unsigned FCW = $clog2(FIFO_DEPTH + 1);

    // Command queue
    cmd_t              cmd_in;
    logic [CMD_W-1:0]  cmd_head;
    logic [CCW-1:0]    cmd_count;
    logic              cmd_full, cmd_empty, cmd_push, cmd_pop;

    // Data FIFOs
    logic [31:0]       wr_head, rd_head;
    logic [FCW-1:0]    wr_count, rd_count;
    logic              wr_full, wr_empty, wr_pop;
    logic              rd_full, rd_empty, rd_push;

    // Sequencer state
    state_e                  state_q;
    logic                    mem_req_q, mem_rw_q;
    logic [BW_WORD_ADDR-1:0] mem_add_q;
    logic [BW_BLOCK-1:0]     cnt_q;
    logic                    blk_q;
    logic                    err_q, err_d;

    // Head command decode and launch condition
    logic                    head_rw, head_blk;
    logic [BW_WORD_ADDR-1:0] head_addr;
    int unsigned             need_words;
    logic                    launch_ok;
    logic [BW_BLOCK-1:0]     last_idx;
    logic                    word_done;

    // Block commands are stored already aligned to the block base.
    always_comb begin
        cmd_in      = '0;
        cmd_in.rw   = rw_i;
        cmd_in.blk  = req_block_i;
        cmd_in.addr = req_block_i ? block_base(add_i) : add_i;
    end

    assign cmd_push = req_i & ~cmd_full;

    fifo_sync_showahead #(
        .WIDTH (CMD_W),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_q (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .push_i  (cmd_push),
        .data_i  (cmd_in),
        .pop_i   (cmd_pop),
        .data_o  (cmd_head),
        .count_o (cmd_count),
        .full_o  (cmd_full),
        .empty_o (cmd_empty)
    );

    fifo_sync_showahead #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .push_i  (write_i),
        .data_i  (data_i),
        .pop_i   (wr_pop),
        .data_o  (wr_head),
        .count_o (wr_count),
        .full_o  (wr_full),
        .empty_o (wr_empty)
    );

    fifo_sync_showahead #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_rd_fifo (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .push_i  (rd_push),
        .data_i  (mem_data_i),
        .pop_i   (read_i),
        .data_o  (rd_head),
        .count_o (rd_count),
        .full_o  (rd_full),
        .empty_o (rd_empty)
    );

    // Decode the queue head and decide whether its data/space is available.
    // A fill reserves all of its read-FIFO space up front, so the read FIFO
    // can never overflow while the transfer is in flight.
    always_comb begin
        head_rw    = cmd_head[CMD_RW];
        head_blk   = cmd_head[CMD_BLOCK];
        head_addr  = cmd_head[CMD_ADDR +: BW_WORD_ADDR];
        need_words = head_blk ? BLOCK_WORDS : 1;
        if (head_rw) begin
            launch_ok = (32'(wr_count) >= need_words);
        end else begin
            launch_ok = (32'(rd_count) + need_words <= FIFO_DEPTH);
        end
        cmd_pop  = (state_q == ST_IDLE) && !cmd_empty && launch_ok;
        last_idx = blk_q ? BW_BLOCK'(BLOCK_WORDS - 1) : '0;
    end

    assign word_done = mem_req_q & mem_done_i;
    assign rd_push   = word_done & (state_q == ST_FILL);
    assign wr_pop    = word_done & (state_q == ST_WRITEBACK);

    // Transfer sequencer: launches the head command and steps through its words.
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_q   <= ST_IDLE;
            mem_req_q <= 1'b0;
            mem_rw_q  <= 1'b0;
            mem_add_q <= '0;
            cnt_q     <= '0;
            blk_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_pop) begin
                        state_q   <= head_rw ? ST_WRITEBACK : ST_FILL;
                        mem_req_q <= 1'b1;
                        mem_rw_q  <= head_rw;
                        mem_add_q <= head_addr;
                        cnt_q     <= '0;
                        blk_q     <= head_blk;
                    end
                end
                ST_FILL, ST_WRITEBACK: begin
                    if (word_done) begin
                        if (cnt_q == last_idx) begin
                            state_q   <= ST_IDLE;
                            mem_req_q <= 1'b0;
                        end else begin
                            // Counter replaces the low address bits, so the
                            // sequence wraps inside the block, never carrying up.
                            cnt_q     <= cnt_q + BW_BLOCK'(1);
                            mem_add_q <= {mem_add_q[BW_WORD_ADDR-1:BW_BLOCK], cnt_q + BW_BLOCK'(1)};
                        end
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    // Protocol errors; the FIFO full/empty terms on the memory side cannot
    // occur by construction and only guard against sequencing faults.
    always_comb begin
        err_d = err_q;
        if ((req_i & cmd_full) | (write_i & wr_full) | (read_i & rd_empty) |
            (mem_done_i & ~mem_req_q) | (rd_push & rd_full) | (wr_pop & wr_empty)) begin
            err_d = 1'b1;
        end
    end

    // Sticky error flag.
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign ready_req_o   = (cmd_count != CCW'(CMD_DEPTH));
    assign ready_write_o = ~wr_full;
    assign ready_read_o  = ~rd_empty;
    assign data_o        = rd_head;
    assign mem_req_o     = mem_req_q;
    assign mem_rw_o      = mem_rw_q;
    assign mem_add_o     = mem_add_q;
    assign mem_data_o    = (state_q == ST_WRITEBACK) ? wr_head : '0;
    assign err_o         = err_q;

endmodule

// File: tb/tb_cache_block_transfer_buffer.sv
// Self-checking bench for cache_block_transfer_buffer: a memory responder
// checks each external word transfer against a scoreboard queue, and read
// FIFO pops are checked against a second queue.
module tb_cache_block_transfer_buffer;

    logic        clock_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        req_i = 1'b0, req_block_i = 1'b0, rw_i = 1'b0;
    logic [15:0] add_i = '0;
    logic        write_i = 1'b0, read_i = 1'b0;
    logic [31:0] data_i = '0;
    logic        ready_req_o, ready_write_o, ready_read_o;
    logic [31:0] data_o;
    logic        mem_req_o, mem_rw_o;
    logic [15:0] mem_add_o;
    logic [31:0] mem_data_o;
    logic        mem_done_i = 1'b0;
    logic [31:0] mem_data_i = '0;
    logic        err_o;

    cache_block_transfer_buffer #(
        .CMD_DEPTH   (2),
        .BLOCK_WORDS (16),
        .FIFO_DEPTH  (16)
    ) dut (
        .clock_i       (clock_i),
        .reset_i       (reset_i),
        .req_i         (req_i),
        .req_block_i   (req_block_i),
        .rw_i          (rw_i),
        .add_i         (add_i),
        .write_i       (write_i),
        .data_i        (data_i),
        .read_i        (read_i),
        .ready_req_o   (ready_req_o),
        .ready_write_o (ready_write_o),
        .ready_read_o  (ready_read_o),
        .data_o        (data_o),
        .mem_req_o     (mem_req_o),
        .mem_rw_o      (mem_rw_o),
        .mem_add_o     (mem_add_o),
        .mem_data_o    (mem_data_o),
        .mem_done_i    (mem_done_i),
        .mem_data_i    (mem_data_i),
        .err_o         (err_o)
    );

    always #5 clock_i = ~clock_i;

    typedef struct {
        logic        rw;
        logic [15:0] addr;
        logic [31:0] data;
    } xfer_t;

    typedef struct {
        logic        blk;
        logic [15:0] add;
        logic [15:0] exp_base;
        int unsigned exp_n;
    } fill_vec_t;

    typedef enum int {M_OFF, M_TIED, M_THIRD} mode_e;

    xfer_t       exp_mem[$];
    logic [31:0] exp_rd[$];
    int          checks = 0;
    int          failures = 0;
    mode_e       mode = M_OFF;
    int          req_cycles = 0;
    int          done_cnt = 0;
    bit          stale_pulse = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // External memory model and transfer scoreboard.
    initial begin
        int third_cnt = 0;
        bit fire;
        xfer_t e;
        forever begin
            @(negedge clock_i);
            fire = 1'b0;
            if (mem_req_o && mode != M_OFF) begin
                req_cycles++;
                fire = (mode == M_TIED) || (third_cnt == 2);
                third_cnt = (third_cnt == 2) ? 0 : third_cnt + 1;
            end
            mem_done_i = fire | stale_pulse;
            stale_pulse = 1'b0;
            if (fire) begin
                done_cnt++;
                mem_data_i = {16'hA5A5, mem_add_o};
                if (exp_mem.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_xfer actual=rw%0d@%h required=none", mem_rw_o, mem_add_o);
                end else begin
                    e = exp_mem.pop_front();
                    chk("xfer_rw", {31'b0, mem_rw_o}, {31'b0, e.rw});
                    chk("xfer_addr", {16'b0, mem_add_o}, {16'b0, e.addr});
                    if (e.rw) chk("xfer_wdata", mem_data_o, e.data);
                end
            end
        end
    end

    // Run until the scoreboard is empty and memory idle; optionally drain the read FIFO.
    task automatic run_until_done(input bit drain, input int unsigned budget, input string tag);
        bit ok = 1'b0;
        for (int unsigned i = 0; i < budget; i++) begin
            @(negedge clock_i);
            read_i = 1'b0;
            if (exp_mem.size() == 0 && !mem_req_o &&
                (!drain || (!ready_read_o && exp_rd.size() == 0))) begin
                ok = 1'b1;
                break;
            end
            if (drain && ready_read_o) begin
                if (exp_rd.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL %s_rd_extra actual=%h required=none", tag, data_o);
                end else begin
                    chk({tag, "_rd"}, data_o, exp_rd.pop_front());
                end
                read_i = 1'b1;
            end
        end
        read_i = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_timeout actual=pending%0d required=0", tag, exp_mem.size() + exp_rd.size());
        end
    endtask

    task automatic send_cmd(input logic rw, input logic blk, input logic [15:0] a);
        @(negedge clock_i);
        req_i = 1'b1; rw_i = rw; req_block_i = blk; add_i = a;
        @(negedge clock_i);
        req_i = 1'b0;
    endtask

    task automatic push_words(input logic [31:0] first);
        for (int unsigned i = 0; i < 16; i++) begin
            @(negedge clock_i);
            write_i = 1'b1; data_i = first + i;
        end
        @(negedge clock_i);
        write_i = 1'b0;
    endtask

    fill_vec_t vecs[4];

    initial begin
        vecs[0] = '{blk: 1'b1, add: 16'h0043, exp_base: 16'h0040, exp_n: 16};
        vecs[1] = '{blk: 1'b0, add: 16'h0007, exp_base: 16'h0007, exp_n: 1};
        vecs[2] = '{blk: 1'b1, add: 16'hFFF5, exp_base: 16'hFFF0, exp_n: 16};
        vecs[3] = '{blk: 1'b0, add: 16'h1235, exp_base: 16'h1235, exp_n: 1};

        // Reset state
        repeat (3) @(negedge clock_i);
        chk("rst_ready_req", {31'b0, ready_req_o}, 32'd1);
        chk("rst_ready_write", {31'b0, ready_write_o}, 32'd1);
        chk("rst_ready_read", {31'b0, ready_read_o}, 32'd0);
        chk("rst_data_o", data_o, 32'd0);
        chk("rst_mem_req", {31'b0, mem_req_o}, 32'd0);
        chk("rst_mem_rw", {31'b0, mem_rw_o}, 32'd0);
        chk("rst_mem_add", {16'b0, mem_add_o}, 32'd0);
        chk("rst_mem_data", mem_data_o, 32'd0);
        chk("rst_err", {31'b0, err_o}, 32'd0);
        reset_i = 1'b1;

        // Fill commands from the vector table
        mode = M_TIED;
        for (int v = 0; v < 4; v++) begin
            for (int unsigned i = 0; i < vecs[v].exp_n; i++) begin
                exp_mem.push_back('{rw: 1'b0, addr: vecs[v].exp_base + 16'(i), data: 32'h0});
                exp_rd.push_back({16'hA5A5, vecs[v].exp_base + 16'(i)});
            end
            req_cycles = 0;
            send_cmd(1'b0, vecs[v].blk, vecs[v].add);
            run_until_done(1'b0, 100, "fill");
            chk("fill_req_cycles", req_cycles, vecs[v].exp_n);
            chk("fill_ready_read", {31'b0, ready_read_o}, 32'd1);
            run_until_done(1'b1, 100, "fill_drain");
            chk("fill_read_empty", {31'b0, ready_read_o}, 32'd0);
        end

        // Writeback with data queued first
        push_words(32'd0);
        chk("wb_fifo_full", {31'b0, ready_write_o}, 32'd0);
        for (int unsigned i = 0; i < 16; i++)
            exp_mem.push_back('{rw: 1'b1, addr: 16'h0120 + 16'(i), data: i});
        @(negedge clock_i);
        req_i = 1'b1; rw_i = 1'b1; req_block_i = 1'b1; add_i = 16'h0120;
        @(negedge clock_i);
        req_i = 1'b0;
        chk("wb_req_before_pop", {31'b0, mem_req_o}, 32'd0);
        @(negedge clock_i);
        chk("wb_req_after_pop", {31'b0, mem_req_o}, 32'd1);
        run_until_done(1'b1, 100, "wb_first");
        chk("wb_ready_write_end", {31'b0, ready_write_o}, 32'd1);
        chk("wb_err_clean", {31'b0, err_o}, 32'd0);

        // Writeback with command queued first, data five cycles later
        begin
            bit early = 1'b0;
            for (int unsigned i = 0; i < 16; i++)
                exp_mem.push_back('{rw: 1'b1, addr: 16'h0200 + 16'(i), data: 32'h1000 + i});
            send_cmd(1'b1, 1'b1, 16'h0200);
            repeat (5) begin
                @(negedge clock_i);
                if (mem_req_o) early = 1'b1;
            end
            for (int unsigned i = 0; i < 16; i++) begin
                @(negedge clock_i);
                if (mem_req_o) early = 1'b1;
                write_i = 1'b1; data_i = 32'h1000 + i;
            end
            @(negedge clock_i);
            write_i = 1'b0;
            if (mem_req_o) early = 1'b1;
            chk("cmdfirst_no_early_req", {31'b0, early}, 32'd0);
            run_until_done(1'b1, 100, "wb_cmdfirst");
        end

        // Ordering and command-queue backpressure, memory done every third cycle
        push_words(32'h2000);
        for (int unsigned i = 0; i < 16; i++) begin
            exp_mem.push_back('{rw: 1'b0, addr: 16'h0300 + 16'(i), data: 32'h0});
            exp_rd.push_back({16'hA5A5, 16'h0300 + 16'(i)});
        end
        for (int unsigned i = 0; i < 16; i++)
            exp_mem.push_back('{rw: 1'b1, addr: 16'h0400 + 16'(i), data: 32'h2000 + i});
        exp_mem.push_back('{rw: 1'b0, addr: 16'h0500, data: 32'h0});
        exp_rd.push_back(32'hA5A50500);
        mode = M_THIRD;
        @(negedge clock_i);
        req_i = 1'b1; rw_i = 1'b0; req_block_i = 1'b1; add_i = 16'h0305;
        @(negedge clock_i);
        rw_i = 1'b1; req_block_i = 1'b1; add_i = 16'h0400;
        @(negedge clock_i);
        rw_i = 1'b0; req_block_i = 1'b0; add_i = 16'h0500;
        @(negedge clock_i);
        chk("order_queue_full", {31'b0, ready_req_o}, 32'd0);
        chk("order_err_before", {31'b0, err_o}, 32'd0);
        rw_i = 1'b1; req_block_i = 1'b0; add_i = 16'h0600;
        @(negedge clock_i);
        req_i = 1'b0;
        chk("order_err_dropped", {31'b0, err_o}, 32'd1);
        run_until_done(1'b1, 600, "order");
        begin
            bit stray = 1'b0;
            repeat (4) begin
                @(negedge clock_i);
                if (mem_req_o) stray = 1'b1;
            end
            chk("order_dropped_not_run", {31'b0, stray}, 32'd0);
        end

        // Reset in the middle of a block fill
        mode = M_TIED;
        for (int unsigned i = 0; i < 16; i++)
            exp_mem.push_back('{rw: 1'b0, addr: 16'h0700 + 16'(i), data: 32'h0});
        done_cnt = 0;
        send_cmd(1'b0, 1'b1, 16'h0700);
        for (int i = 0; i < 100 && done_cnt < 5; i++) @(negedge clock_i);
        chk("midfill_progress", {31'b0, done_cnt >= 5}, 32'd1);
        reset_i = 1'b0;
        mode = M_OFF;
        @(negedge clock_i);
        chk("midfill_mem_req", {31'b0, mem_req_o}, 32'd0);
        chk("midfill_ready_read", {31'b0, ready_read_o}, 32'd0);
        chk("midfill_ready_req", {31'b0, ready_req_o}, 32'd1);
        exp_mem.delete();
        exp_rd.delete();
        reset_i = 1'b1;
        @(negedge clock_i);
        stale_pulse = 1'b1;
        repeat (3) @(negedge clock_i);
        chk("stale_done_no_push", {31'b0, ready_read_o}, 32'd0);
        chk("stale_done_no_req", {31'b0, mem_req_o}, 32'd0);
        chk("stale_done_err", {31'b0, err_o}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
